iadder_arbiter: RTL and testbench

Shares the single immediate adder (src + imm, src = rs1 or pc) between two requesters:
- the branch/jump unit (BR): branch/JAL targets from pc, JALR targets from rs1;
- the load/store unit (LS): effective address, always rs1-based.

It drives the adder's operand/select inputs, captures the sum and returns it to the owning requester over a valid/ready response channel. It sits in the execute stage between those units and the adder instance.

---
 rtl/iadder_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/iadder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_iadder_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iadder_arb_pkg.sv
// Shared types and constants for the immediate-adder arbiter.
package iadder_arb_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_BR = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; bit 0 is the BR requester, bit 1 the LS requester.
module rr_arb2
    import iadder_arb_pkg::*;
(
    input  logic [1:0] valid_in,
    input  logic       last_grant_in,
    output logic [1:0] grant_out
);

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_out = 2'b00;
        if (valid_in == 2'b11) begin
            grant_out = (last_grant_in == OWN_LS) ? 2'b01 : 2'b10;
        end else begin
            grant_out = valid_in;
        end
    end

endmodule

// File: rtl/iadder_arbiter.sv
// Shares one immediate adder between the branch unit and the load/store unit.
// Optional macro IADDER_JALR_LSB_CLR_EN clears bit 0 of BR JALR targets.
module iadder_arbiter
    import iadder_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            br_valid_in,
    output logic            br_ready_out,
    input  logic [XLEN-1:0] br_pc_in,
    input  logic [XLEN-1:0] br_rs1_in,
    input  logic [XLEN-1:0] br_imm_in,
    input  logic            br_src_in,
    input  logic            br_jalr_in,
    input  logic            ls_valid_in,
    output logic            ls_ready_out,
    input  logic [XLEN-1:0] ls_rs1_in,
    input  logic [XLEN-1:0] ls_imm_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] imm_out,
    output logic            iadder_src_out,
    input  logic [XLEN-1:0] iadder_in,
    output logic            br_resp_valid_out,
    input  logic            br_resp_ready_in,
    output logic [XLEN-1:0] br_addr_out,
    output logic            ls_resp_valid_out,
    input  logic            ls_resp_ready_in,
    output logic [XLEN-1:0] ls_addr_out
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              src_q, src_d;
    logic [XLEN-1:0]   br_addr_q, br_addr_d;
    logic [XLEN-1:0]   ls_addr_q, ls_addr_d;
    logic              br_resp_valid_q, br_resp_valid_d;
    logic              ls_resp_valid_q, ls_resp_valid_d;
    logic [XLEN-1:0]   result;
    logic [1:0]        grant;

`ifdef IADDER_JALR_LSB_CLR_EN
    logic              jalr_q, jalr_d;
`else
    logic              unused_jalr;
    assign unused_jalr = br_jalr_in;
`endif

    rr_arb2 u_rr_arb2 (
        .valid_in      ({ls_valid_in, br_valid_in}),
        .last_grant_in (last_grant_q),
        .grant_out     (grant)
    );

    assign br_ready_out      = (state_q == IDLE) && grant[0];
    assign ls_ready_out      = (state_q == IDLE) && grant[1];
    assign pc_out            = pc_q;
    assign rs1_out           = rs1_q;
    assign imm_out           = imm_q;
    assign iadder_src_out    = src_q;
    assign br_addr_out       = br_addr_q;
    assign ls_addr_out       = ls_addr_q;
    assign br_resp_valid_out = br_resp_valid_q;
    assign ls_resp_valid_out = ls_resp_valid_q;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        pc_d            = pc_q;
        rs1_d           = rs1_q;
        imm_d           = imm_q;
        src_d           = src_q;
        br_addr_d       = br_addr_q;
        ls_addr_d       = ls_addr_q;
        br_resp_valid_d = br_resp_valid_q;
        ls_resp_valid_d = ls_resp_valid_q;
        result          = iadder_in;
`ifdef IADDER_JALR_LSB_CLR_EN
        jalr_d          = jalr_q;
        if (owner_q == OWN_BR && jalr_q) begin
            result[0] = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    pc_d         = br_pc_in;
                    rs1_d        = br_rs1_in;
                    imm_d        = br_imm_in;
                    src_d        = br_src_in;
`ifdef IADDER_JALR_LSB_CLR_EN
                    jalr_d       = br_jalr_in;
`endif
                    owner_d      = OWN_BR;
                    last_grant_d = OWN_BR;
                    state_d      = CALC;
                end else if (grant[1]) begin
                    // LS addresses are always base-relative, so force the rs1 path.
                    pc_d         = '0;
                    rs1_d        = ls_rs1_in;
                    imm_d        = ls_imm_in;
                    src_d        = 1'b1;
`ifdef IADDER_JALR_LSB_CLR_EN
                    jalr_d       = 1'b0;
`endif
                    owner_d      = OWN_LS;
                    last_grant_d = OWN_LS;
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (owner_q == OWN_BR) begin
                    br_addr_d       = result;
                    br_resp_valid_d = 1'b1;
                end else begin
                    ls_addr_d       = result;
                    ls_resp_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q == OWN_BR && br_resp_ready_in) begin
                    br_resp_valid_d = 1'b0;
                    state_d         = IDLE;
                end else if (owner_q == OWN_LS && ls_resp_ready_in) begin
                    ls_resp_valid_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            last_grant_q    <= OWN_LS;
            owner_q         <= OWN_BR;
            pc_q            <= '0;
            rs1_q           <= '0;
            imm_q           <= '0;
            src_q           <= 1'b0;
            br_addr_q       <= '0;
            ls_addr_q       <= '0;
            br_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
`ifdef IADDER_JALR_LSB_CLR_EN
            jalr_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            pc_q            <= pc_d;
            rs1_q           <= rs1_d;
            imm_q           <= imm_d;
            src_q           <= src_d;
            br_addr_q       <= br_addr_d;
            ls_addr_q       <= ls_addr_d;
            br_resp_valid_q <= br_resp_valid_d;
            ls_resp_valid_q <= ls_resp_valid_d;
`ifdef IADDER_JALR_LSB_CLR_EN
            jalr_q          <= jalr_d;
`endif
        end
    end

endmodule

// File: tb/tb_iadder_arbiter.sv
// Directed self-checking bench for iadder_arbiter with a behavioural adder model.
module tb_iadder_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        br_valid_in, br_ready_out;
    logic [31:0] br_pc_in, br_rs1_in, br_imm_in;
    logic        br_src_in, br_jalr_in;
    logic        ls_valid_in, ls_ready_out;
    logic [31:0] ls_rs1_in, ls_imm_in;
    logic [31:0] pc_out, rs1_out, imm_out;
    logic        iadder_src_out;
    logic [31:0] iadder_in;
    logic        br_resp_valid_out, br_resp_ready_in;
    logic [31:0] br_addr_out;
    logic        ls_resp_valid_out, ls_resp_ready_in;
    logic [31:0] ls_addr_out;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk_in = ~clk_in;

    // Stand-in for the shared immediate adder.
    assign iadder_in = (iadder_src_out ? rs1_out : pc_out) + imm_out;

    iadder_arbiter #(.XLEN(32)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .br_valid_in       (br_valid_in),
        .br_ready_out      (br_ready_out),
        .br_pc_in          (br_pc_in),
        .br_rs1_in         (br_rs1_in),
        .br_imm_in         (br_imm_in),
        .br_src_in         (br_src_in),
        .br_jalr_in        (br_jalr_in),
        .ls_valid_in       (ls_valid_in),
        .ls_ready_out      (ls_ready_out),
        .ls_rs1_in         (ls_rs1_in),
        .ls_imm_in         (ls_imm_in),
        .pc_out            (pc_out),
        .rs1_out           (rs1_out),
        .imm_out           (imm_out),
        .iadder_src_out    (iadder_src_out),
        .iadder_in         (iadder_in),
        .br_resp_valid_out (br_resp_valid_out),
        .br_resp_ready_in  (br_resp_ready_in),
        .br_addr_out       (br_addr_out),
        .ls_resp_valid_out (ls_resp_valid_out),
        .ls_resp_ready_in  (ls_resp_ready_in),
        .ls_addr_out       (ls_addr_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " br_ready"}, {31'd0, br_ready_out}, 32'd0);
        checkOutput({tag, " ls_ready"}, {31'd0, ls_ready_out}, 32'd0);
        checkOutput({tag, " br_resp_valid"}, {31'd0, br_resp_valid_out}, 32'd0);
        checkOutput({tag, " ls_resp_valid"}, {31'd0, ls_resp_valid_out}, 32'd0);
        checkOutput({tag, " br_addr"}, br_addr_out, 32'd0);
        checkOutput({tag, " ls_addr"}, ls_addr_out, 32'd0);
        checkOutput({tag, " pc_out"}, pc_out, 32'd0);
        checkOutput({tag, " rs1_out"}, rs1_out, 32'd0);
        checkOutput({tag, " imm_out"}, imm_out, 32'd0);
        checkOutput({tag, " src_out"}, {31'd0, iadder_src_out}, 32'd0);
    endtask

    // Full BR transaction with resp_ready held high: accept, CALC, RESP, back to IDLE.
    task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic [31:0] rs1,
                                 input logic [31:0] imm, input logic src, input logic jalr,
                                 input logic [31:0] expAddr);
        @(negedge clk_in);
        br_valid_in = 1'b1; br_pc_in = pc; br_rs1_in = rs1; br_imm_in = imm;
        br_src_in = src; br_jalr_in = jalr; br_resp_ready_in = 1'b1;
        #1;
        checkOutput({tag, " br_ready at accept"}, {31'd0, br_ready_out}, 32'd1);
        @(negedge clk_in);
        br_valid_in = 1'b0;
        checkOutput({tag, " br_ready in CALC"}, {31'd0, br_ready_out}, 32'd0);
        checkOutput({tag, " resp_valid in CALC"}, {31'd0, br_resp_valid_out}, 32'd0);
        @(negedge clk_in);
        checkOutput({tag, " br_resp_valid"}, {31'd0, br_resp_valid_out}, 32'd1);
        checkOutput({tag, " br_addr"}, br_addr_out, expAddr);
        checkOutput({tag, " ls_resp_valid"}, {31'd0, ls_resp_valid_out}, 32'd0);
        @(negedge clk_in);
        checkOutput({tag, " resp cleared"}, {31'd0, br_resp_valid_out}, 32'd0);
    endtask

    initial begin
        logic [31:0] jalrExpA, jalrExpB;
        rst_in = 1'b0;
        br_valid_in = 0; br_pc_in = 0; br_rs1_in = 0; br_imm_in = 0; br_src_in = 0; br_jalr_in = 0;
        ls_valid_in = 0; ls_rs1_in = 0; ls_imm_in = 0;
        br_resp_ready_in = 0; ls_resp_ready_in = 0;

        @(negedge clk_in);
        checkAllZero("reset");
        rst_in = 1'b1;

        applyStimulus("br_pc", 32'h100, 32'h0, 32'h20, 1'b0, 1'b0, 32'h120);
        checkOutput("br_pc ls_addr untouched", ls_addr_out, 32'd0);

        // LS with a stalled consumer, while BR waits for its turn.
        @(negedge clk_in);
        ls_valid_in = 1'b1; ls_rs1_in = 32'h1000; ls_imm_in = 32'hFFFF_FFFC; ls_resp_ready_in = 1'b0;
        #1;
        checkOutput("ls ready at accept", {31'd0, ls_ready_out}, 32'd1);
        checkOutput("ls br_ready idle", {31'd0, br_ready_out}, 32'd0);
        @(negedge clk_in);
        ls_valid_in = 1'b0;
        br_valid_in = 1'b1; br_src_in = 1'b1; br_rs1_in = 32'hFFFF_FFF0; br_imm_in = 32'h20;
        br_pc_in = 32'h5555_0000; br_jalr_in = 1'b0; br_resp_ready_in = 1'b1;
        checkOutput("ls calc pc_out", pc_out, 32'd0);
        checkOutput("ls calc rs1_out", rs1_out, 32'h1000);
        checkOutput("ls calc src_out", {31'd0, iadder_src_out}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checkOutput($sformatf("ls stall%0d valid", i), {31'd0, ls_resp_valid_out}, 32'd1);
            checkOutput($sformatf("ls stall%0d addr", i), ls_addr_out, 32'h0000_0FFC);
            checkOutput($sformatf("ls stall%0d br_ready", i), {31'd0, br_ready_out}, 32'd0);
            checkOutput($sformatf("ls stall%0d br_valid_out", i), {31'd0, br_resp_valid_out}, 32'd0);
        end
        ls_resp_ready_in = 1'b1;
        @(negedge clk_in);
        checkOutput("ls resp cleared", {31'd0, ls_resp_valid_out}, 32'd0);
        checkOutput("wrap br_ready", {31'd0, br_ready_out}, 32'd1);
        @(negedge clk_in);
        br_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("wrap br_resp_valid", {31'd0, br_resp_valid_out}, 32'd1);
        checkOutput("wrap br_addr", br_addr_out, 32'h10);

`ifdef IADDER_JALR_LSB_CLR_EN
        jalrExpA = 32'h2004; jalrExpB = 32'h2002;
`else
        jalrExpA = 32'h2005; jalrExpB = 32'h2003;
`endif
        applyStimulus("jalr_a", 32'h0, 32'h2001, 32'h4, 1'b1, 1'b1, jalrExpA);
        applyStimulus("jalr_b", 32'h0, 32'h2000, 32'h3, 1'b1, 1'b1, jalrExpB);
        applyStimulus("nojalr", 32'h0, 32'h2000, 32'h3, 1'b1, 1'b0, 32'h2003);

        // Reset while a BR request is in CALC.
        @(negedge clk_in);
        br_valid_in = 1'b1; br_pc_in = 32'h400; br_imm_in = 32'h8; br_src_in = 1'b0; br_jalr_in = 1'b0;
        @(negedge clk_in);
        br_valid_in = 1'b0;
        checkOutput("midreset calc pc_out", pc_out, 32'h400);
        rst_in = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            checkOutput($sformatf("dropped%0d br_resp_valid", i), {31'd0, br_resp_valid_out}, 32'd0);
        end

        // Continuous tie: expected grants BR, LS, BR, LS at 3-cycle spacing.
        br_valid_in = 1'b1; br_pc_in = 32'h40; br_imm_in = 32'h4; br_src_in = 1'b0;
        ls_valid_in = 1'b1; ls_rs1_in = 32'h300; ls_imm_in = 32'h10;
        br_resp_ready_in = 1'b1; ls_resp_ready_in = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            logic expBr, expLs;
            expBr = (i % 3 == 0) && ((i / 3) % 2 == 0);
            expLs = (i % 3 == 0) && ((i / 3) % 2 == 1);
            checkOutput($sformatf("tie%0d br_ready", i), {31'd0, br_ready_out}, {31'd0, expBr});
            checkOutput($sformatf("tie%0d ls_ready", i), {31'd0, ls_ready_out}, {31'd0, expLs});
            if (i % 3 == 2) begin
                if ((i / 3) % 2 == 0) begin
                    checkOutput($sformatf("tie%0d br_valid", i), {31'd0, br_resp_valid_out}, 32'd1);
                    checkOutput($sformatf("tie%0d br_addr", i), br_addr_out, 32'h44);
                end else begin
                    checkOutput($sformatf("tie%0d ls_valid", i), {31'd0, ls_resp_valid_out}, 32'd1);
                    checkOutput($sformatf("tie%0d ls_addr", i), ls_addr_out, 32'h310);
                end
            end
            @(negedge clk_in);
            #1;
        end
        br_valid_in = 1'b0; ls_valid_in = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
